// File: rtl/ddr_cal_pkg.sv
// Shared types and constants for the DQ read-calibration sequencer.
package ddr_cal_pkg;

  // Sequencer states, in the order the calibration walks through them.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WDRAIN,
    START,
    SETTLE,
    READ,
    RDRAIN,
    CHECK
  } calState_t;

  // Per-byte training pattern the banks drive while ForceA is high (0xAA..AA across the bus).
  localparam logic [7:0] CAL_PATTERN = 8'hAA;

  // Larger of two elaboration-time integers, used to size a shared timer.
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_lat_pipe.sv
// Fixed-depth 1-bit delay line for command-to-burst latency. Several strobes
// may be in flight at once; "empty" is high when none are.
module ddr_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic MCLK90,
  input  logic M90Reset,
  input  logic strobeIn,
  output logic strobeOut,
  output logic empty
);

  logic [DEPTH-1:0] stages;

  // Advance every strobe one stage per clock; reset flushes anything in flight.
  always_ff @(posedge MCLK90 or posedge M90Reset) begin
    if (M90Reset) begin
      stages <= '0;
    end else begin
      stages[0] <= strobeIn;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign strobeOut = stages[DEPTH-1];
  assign empty     = (stages == '0);

endmodule

// File: rtl/ddr_cal_sequencer.sv
// Central DQ read-calibration initiator: writes the training pattern, kicks
// every bank calibrator, issues the calibration reads and reports the result.
//
// state  | meaning
// IDLE   | waiting for StartCal; status outputs hold the last result
// WRITE  | ForceA high, pattern writes requested back-to-back
// WDRAIN | ForceA high, write pipe draining plus 2 cycles for bank capture
// START  | single StartDQCal pulse to all banks
// SETTLE | fixed wait before the first calibration read
// READ   | read requests, CmdValid held low RD_GAP cycles after each accept
// RDRAIN | read pipe draining, then FINISH_WAIT cycles for tap adjustment
// CHECK  | CalFail captured into FailMask, CalDone or CalError set
module ddr_cal_sequencer #(
  parameter int NBANKS      = 6,
  parameter int NWRITES     = 4,
  parameter int NREADS      = 64,
  parameter int WR_LAT      = 6,
  parameter int RD_LAT      = 8,
  parameter int RD_GAP      = 4,
  parameter int SETTLE      = 4,
  parameter int FINISH_WAIT = 256
) (
  input  logic              MCLK90,
  input  logic              M90Reset,
  input  logic              StartCal,
  output logic              CmdValid,
  output logic              CmdWrite,
  input  logic              CmdReady,
  output logic              ForceA,
  output logic              StartDQCal,
  output logic              WriteBurst,
  output logic              ReadBurst,
  input  logic [NBANKS-1:0] CalFail,
  output logic              CalBusy,
  output logic              CalDone,
  output logic              CalError,
  output logic [NBANKS-1:0] FailMask
);

  // The SETTLE parameter hides the SETTLE state name, so that state is
  // always referenced through the package scope below.
  import ddr_cal_pkg::*;

  localparam int WCW = $clog2(NWRITES + 1);
  localparam int RCW = $clog2(NREADS + 1);
  localparam int GCW = $clog2(RD_GAP + 1);
  localparam int TCW = $clog2(maxOf(SETTLE, FINISH_WAIT) + 1);

  localparam logic [WCW-1:0] WR_LAST     = WCW'(NWRITES - 1);
  localparam logic [RCW-1:0] RD_LAST     = RCW'(NREADS - 1);
  localparam logic [GCW-1:0] GAP_LOAD    = GCW'(RD_GAP);
  localparam logic [TCW-1:0] SETTLE_LOAD = TCW'(SETTLE - 1);
  localparam logic [TCW-1:0] FINISH_LOAD = TCW'(FINISH_WAIT - 1);

  calState_t state;
  calState_t stateNext;

  logic [WCW-1:0] wrCnt;
  logic [RCW-1:0] rdCnt;
  logic [GCW-1:0] gapCnt;
  logic [1:0]     drainTmr;
  logic [TCW-1:0] waitTmr;

  logic cmdAccept;
  logic wrAccept;
  logic rdAccept;
  logic wrEmpty;
  logic rdEmpty;

  assign cmdAccept = CmdValid & CmdReady;
  assign wrAccept  = cmdAccept & CmdWrite;
  assign rdAccept  = cmdAccept & ~CmdWrite;

  ddr_lat_pipe #(.DEPTH(WR_LAT)) wrPipe (
    .MCLK90    (MCLK90),
    .M90Reset  (M90Reset),
    .strobeIn  (wrAccept),
    .strobeOut (WriteBurst),
    .empty     (wrEmpty)
  );

  ddr_lat_pipe #(.DEPTH(RD_LAT)) rdPipe (
    .MCLK90    (MCLK90),
    .M90Reset  (M90Reset),
    .strobeIn  (rdAccept),
    .strobeOut (ReadBurst),
    .empty     (rdEmpty)
  );

  // State register.
  always_ff @(posedge MCLK90 or posedge M90Reset) begin
    if (M90Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and the per-state command/strobe outputs.
  always_comb begin
    stateNext  = state;
    CmdValid   = 1'b0;
    CmdWrite   = 1'b0;
    ForceA     = 1'b0;
    StartDQCal = 1'b0;
    CalBusy    = (state != IDLE);
    case (state)
      IDLE: begin
        if (StartCal) stateNext = WRITE;
      end
      WRITE: begin
        ForceA   = 1'b1;
        CmdValid = 1'b1;
        CmdWrite = 1'b1;
        if (CmdReady && (wrCnt == WR_LAST)) stateNext = WDRAIN;
      end
      WDRAIN: begin
        ForceA = 1'b1;
        if (wrEmpty && (drainTmr == 2'd0)) stateNext = START;
      end
      START: begin
        StartDQCal = 1'b1;
        stateNext  = ddr_cal_pkg::SETTLE;
      end
      ddr_cal_pkg::SETTLE: begin
        if (waitTmr == '0) stateNext = READ;
      end
      READ: begin
        CmdValid = (gapCnt == '0);
        if ((gapCnt == '0) && CmdReady && (rdCnt == RD_LAST)) stateNext = RDRAIN;
      end
      RDRAIN: begin
        if (rdEmpty && (waitTmr == '0)) stateNext = CHECK;
      end
      CHECK: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Command counters and down-count timers; timers reload while their pipe is still busy.
  always_ff @(posedge MCLK90 or posedge M90Reset) begin
    if (M90Reset) begin
      wrCnt    <= '0;
      rdCnt    <= '0;
      gapCnt   <= '0;
      drainTmr <= 2'd0;
      waitTmr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wrCnt    <= '0;
          rdCnt    <= '0;
          gapCnt   <= '0;
          drainTmr <= 2'd1;
          waitTmr  <= '0;
        end
        WRITE: begin
          if (wrAccept) wrCnt <= wrCnt + WCW'(1);
        end
        WDRAIN: begin
          if (!wrEmpty) begin
            drainTmr <= 2'd1;
          end else if (drainTmr != 2'd0) begin
            drainTmr <= drainTmr - 2'd1;
          end
        end
        START: begin
          waitTmr <= SETTLE_LOAD;
        end
        ddr_cal_pkg::SETTLE: begin
          if (waitTmr != '0) waitTmr <= waitTmr - TCW'(1);
        end
        READ: begin
          if (rdAccept) begin
            rdCnt  <= rdCnt + RCW'(1);
            gapCnt <= GAP_LOAD;
          end else if (gapCnt != '0) begin
            gapCnt <= gapCnt - GCW'(1);
          end
        end
        RDRAIN: begin
          if (!rdEmpty) begin
            waitTmr <= FINISH_LOAD;
          end else if (waitTmr != '0) begin
            waitTmr <= waitTmr - TCW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky result flags: cleared on a fresh start, loaded once in CHECK.
  always_ff @(posedge MCLK90 or posedge M90Reset) begin
    if (M90Reset) begin
      CalDone  <= 1'b0;
      CalError <= 1'b0;
      FailMask <= '0;
    end else if ((state == IDLE) && StartCal) begin
      CalDone  <= 1'b0;
      CalError <= 1'b0;
      FailMask <= '0;
    end else if (state == CHECK) begin
      FailMask <= CalFail;
      CalError <= |CalFail;
      CalDone  <= ~|CalFail;
    end
  end

endmodule

// File: tb/tb_ddr_cal_sequencer.sv
// Scoreboard bench for ddr_cal_sequencer: the driver pushes the expected
// calibration result at each StartCal, the monitor pushes expected burst
// times at each accept and pops/compares whenever the DUT presents an output.
module tb_ddr_cal_sequencer;

  localparam int NB  = 6;
  localparam int NW  = 4;
  localparam int NR  = 64;
  localparam int WRL = 6;
  localparam int RDL = 8;
  localparam int GAP = 4;
  localparam int STL = 4;
  localparam int FW  = 256;

  logic          MCLK90   = 1'b0;
  logic          M90Reset = 1'b0;
  logic          StartCal = 1'b0;
  logic          CmdReady = 1'b0;
  logic [NB-1:0] CalFail  = '0;
  logic          CmdValid, CmdWrite, ForceA, StartDQCal, WriteBurst, ReadBurst;
  logic          CalBusy, CalDone, CalError;
  logic [NB-1:0] FailMask;

  typedef struct {
    logic          done;
    logic          err;
    logic [NB-1:0] mask;
  } res_t;

  res_t resQ[$];
  int   wrQ[$];
  int   rdQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wrAcc = 0, rdAcc = 0, wbCnt = 0, rbCnt = 0, dqCnt = 0;
  int lastRdAcc = 0, startDqCyc = 0, lastRb = 0, resCnt = 0, expCyc = 0;
  bit holdPend = 0, prevWrite = 0, prevDone = 0, prevErr = 0, clearPend = 0;
  int readyMode = 0, readyPh = 0;
  logic [NB-1:0] failVal = '0;
  res_t got;

  ddr_cal_sequencer #(
    .NBANKS(NB), .NWRITES(NW), .NREADS(NR), .WR_LAT(WRL), .RD_LAT(RDL),
    .RD_GAP(GAP), .SETTLE(STL), .FINISH_WAIT(FW)
  ) dut (
    .MCLK90(MCLK90), .M90Reset(M90Reset), .StartCal(StartCal),
    .CmdValid(CmdValid), .CmdWrite(CmdWrite), .CmdReady(CmdReady),
    .ForceA(ForceA), .StartDQCal(StartDQCal), .WriteBurst(WriteBurst),
    .ReadBurst(ReadBurst), .CalFail(CalFail), .CalBusy(CalBusy),
    .CalDone(CalDone), .CalError(CalError), .FailMask(FailMask)
  );

  always #5 MCLK90 = ~MCLK90;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic checkIdle(input string tag);
    chk(CmdValid == 1'b0,   {tag, "_CmdValid"},   CmdValid, 0);
    chk(CmdWrite == 1'b0,   {tag, "_CmdWrite"},   CmdWrite, 0);
    chk(ForceA == 1'b0,     {tag, "_ForceA"},     ForceA, 0);
    chk(StartDQCal == 1'b0, {tag, "_StartDQCal"}, StartDQCal, 0);
    chk(WriteBurst == 1'b0, {tag, "_WriteBurst"}, WriteBurst, 0);
    chk(ReadBurst == 1'b0,  {tag, "_ReadBurst"},  ReadBurst, 0);
    chk(CalBusy == 1'b0,    {tag, "_CalBusy"},    CalBusy, 0);
    chk(CalDone == 1'b0,    {tag, "_CalDone"},    CalDone, 0);
    chk(CalError == 1'b0,   {tag, "_CalError"},   CalError, 0);
    chk(FailMask == '0,     {tag, "_FailMask"},   FailMask, 0);
  endtask

  // Issuer/bank stimulus: ready pattern per mode, bank failure flags once 20 reads are in.
  initial begin
    forever begin
      @(posedge MCLK90);
      #1;
      readyPh++;
      case (readyMode)
        0:       CmdReady = 1'b1;
        1:       CmdReady = ((readyPh % 4) == 0);
        default: CmdReady = ($urandom_range(0, 1) == 1);
      endcase
      CalFail = (rdAcc >= 20) ? failVal : '0;
    end
  end

  // Monitor: records accepts, pops the scoreboard on every burst and result.
  initial begin
    forever begin
      @(negedge MCLK90);
      cyc++;
      if (M90Reset) begin
        wrQ.delete();
        rdQ.delete();
        holdPend  = 0;
        prevDone  = 0;
        prevErr   = 0;
        clearPend = 0;
      end else begin
        if (clearPend) begin
          chk(CalDone == 1'b0,  "clear_done",  CalDone, 0);
          chk(CalError == 1'b0, "clear_error", CalError, 0);
          chk(FailMask == '0,   "clear_mask",  FailMask, 0);
          chk(CalBusy == 1'b1,  "busy_start",  CalBusy, 1);
          clearPend = 0;
        end
        if (StartCal && !CalBusy) begin
          wrAcc = 0; rdAcc = 0; wbCnt = 0; rbCnt = 0; dqCnt = 0;
          clearPend = 1;
        end
        if (holdPend) begin
          chk(CmdValid == 1'b1,      "hold_valid", CmdValid, 1);
          chk(CmdWrite == prevWrite, "hold_write", CmdWrite, prevWrite);
        end
        holdPend  = CmdValid && !CmdReady;
        prevWrite = CmdWrite;
        if (CmdValid && CmdReady) begin
          if (CmdWrite) begin
            wrQ.push_back(cyc + WRL);
            wrAcc++;
            chk(ForceA == 1'b1, "forcea_wr", ForceA, 1);
          end else begin
            rdQ.push_back(cyc + RDL);
            chk(dqCnt == 1, "dq_before_rd", dqCnt, 1);
            chk(ForceA == 1'b0, "forcea_rd", ForceA, 0);
            if (rdAcc == 0) chk(cyc - startDqCyc >= STL + 1, "settle_len", cyc - startDqCyc, STL + 1);
            else            chk(cyc - lastRdAcc >= GAP + 1, "rd_gap", cyc - lastRdAcc, GAP + 1);
            lastRdAcc = cyc;
            rdAcc++;
          end
        end
        if (WriteBurst) begin
          wbCnt++;
          chk(ForceA == 1'b1, "forcea_wb", ForceA, 1);
          chk(wrQ.size() != 0, "wb_expected", wrQ.size(), 1);
          if (wrQ.size() != 0) begin
            expCyc = wrQ.pop_front();
            chk(cyc == expCyc, "wb_latency", cyc, expCyc);
          end
        end
        if (ReadBurst) begin
          rbCnt++;
          lastRb = cyc;
          chk(rdQ.size() != 0, "rb_expected", rdQ.size(), 1);
          if (rdQ.size() != 0) begin
            expCyc = rdQ.pop_front();
            chk(cyc == expCyc, "rb_latency", cyc, expCyc);
          end
        end
        if (StartDQCal) begin
          dqCnt++;
          startDqCyc = cyc;
          chk(wbCnt == NW,    "dq_after_wb", wbCnt, NW);
          chk(ForceA == 1'b0, "forcea_dq", ForceA, 0);
        end
        if ((CalDone && !prevDone) || (CalError && !prevErr)) begin
          resCnt++;
          chk(CalBusy == 1'b0, "busy_after_check", CalBusy, 0);
          chk(resQ.size() != 0, "result_expected", resQ.size(), 1);
          if (resQ.size() != 0) begin
            got = resQ.pop_front();
            chk(CalDone == got.done,  "cal_done",  CalDone, got.done);
            chk(CalError == got.err,  "cal_error", CalError, got.err);
            chk(FailMask == got.mask, "fail_mask", FailMask, got.mask);
          end
          chk(wrAcc == NW, "wr_accepts", wrAcc, NW);
          chk(rdAcc == NR, "rd_accepts", rdAcc, NR);
          chk(wbCnt == NW, "wb_count", wbCnt, NW);
          chk(rbCnt == NR, "rb_count", rbCnt, NR);
          chk(dqCnt == 1,  "dq_count", dqCnt, 1);
          chk(cyc - lastRb >= FW, "finish_wait", cyc - lastRb, FW);
        end else if (CalBusy) begin
          chk(!CalDone && !CalError, "status_while_busy", {CalDone, CalError}, 0);
        end
        prevDone = CalDone;
        prevErr  = CalError;
      end
    end
  end

  // One calibration run; the expected result is pushed as StartCal is issued.
  task automatic runCal(input int rmode, input logic [NB-1:0] fv, input bit midStart, input int resetAfter);
    res_t r;
    int   r0;
    int   n;
    readyMode = rmode;
    r.done = (fv == '0);
    r.err  = (fv != '0);
    r.mask = fv;
    r0 = resCnt;
    @(posedge MCLK90); #1;
    StartCal = 1'b1;
    resQ.push_back(r);
    @(posedge MCLK90); #1;
    StartCal = 1'b0;
    failVal  = fv;
    if (midStart) begin
      n = 0;
      while (!StartDQCal && n < 500) begin
        @(negedge MCLK90);
        n++;
      end
      chk(StartDQCal == 1'b1, "dq_seen", StartDQCal, 1);
      @(posedge MCLK90); #1;
      @(posedge MCLK90); #1;
      StartCal = 1'b1;
      @(posedge MCLK90); #1;
      StartCal = 1'b0;
    end
    if (resetAfter > 0) begin
      n = 0;
      while (rdAcc < resetAfter && n < 4000) begin
        @(negedge MCLK90);
        n++;
      end
      chk(rdAcc >= resetAfter, "reads_before_reset", rdAcc, resetAfter);
      #2;
      M90Reset = 1'b1;
      #1;
      checkIdle("mid_reset");
      resQ.delete();
      n = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge MCLK90);
        if (ReadBurst) n++;
      end
      @(posedge MCLK90); #1;
      M90Reset = 1'b0;
      for (int i = 0; i < RDL + 6; i++) begin
        @(negedge MCLK90);
        if (ReadBurst) n++;
      end
      chk(n == 0, "rb_after_reset", n, 0);
      checkIdle("post_reset");
    end else begin
      for (n = 0; n < 4000 && resCnt == r0; n++) @(negedge MCLK90);
      chk(resCnt != r0, "cal_timeout", resCnt - r0, 1);
      if (resCnt == r0) begin
        @(posedge MCLK90); #1;
        M90Reset = 1'b1;
        @(posedge MCLK90); #1;
        M90Reset = 1'b0;
        resQ.delete();
      end
      repeat (3) @(posedge MCLK90);
    end
  endtask

  initial begin
    logic [NB-1:0] fv;
    #2;
    M90Reset = 1'b1;
    #1;
    checkIdle("reset");
    repeat (3) @(posedge MCLK90);
    #1;
    M90Reset = 1'b0;

    runCal(0, '0, 1'b0, 0);
    runCal(1, '0, 1'b0, 0);
    runCal(0, 6'b000100, 1'b0, 0);
    runCal(0, '0, 1'b0, 20);
    runCal(0, '0, 1'b0, 0);
    runCal(0, '0, 1'b1, 0);
    runCal(2, 6'b100001, 1'b0, 0);
    runCal(2, '0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      fv = ($urandom_range(0, 2) == 0) ? NB'($urandom_range(1, 63)) : '0;
      runCal(k % 3, fv, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
